riscv_core_wb_arb: RTL
======================

Name: riscv_core_wb_arb

Overview:
- Shares the register file's single write port (we3/a3/wd3) among NREQ writeback requesters, e.g. ALU, LSU and CSR/debug.
- Uses round-robin arbitration over a valid/ready handshake.
- Keeps a 32-entry busy scoreboard: issue marks rd pending; the granted writeback clears it.
- Sits between the execute/memory units and the register file. Its outputs drive the RF write port directly.

Parameters:
- NREQ, 3, number of writeback requesters (2..8); index 0 has the highest initial priority.
- XLEN, 64, data width; matches the RF.

Ports:
- i_wb_clk  input  1  core clock. All state updates on posedge.
- i_wb_rst_n  input  1  synchronous active-low reset.
- i_wb_req_valid  input  NREQ  per-requester writeback valid.
- i_wb_req_rd  input  NREQ*5  per-requester destination register; requester k uses bits [5k+4:5k].
- i_wb_req_data  input  NREQ*XLEN  per-requester result; requester k uses bits [XLEN*k+XLEN-1:XLEN*k].
- o_wb_req_ready  output  NREQ  one-hot grant. Combinational from valid and the rr pointer.
- i_wb_iss_valid  input  1  an instruction with a destination is issued this cycle.
- i_wb_iss_rd  input  5  destination of the issued instruction.
- i_wb_flush  input  1  pipeline flush; clears the scoreboard.
- o_wb_busy  output  32  scoreboard; bit r=1 means register r has a pending write.
- o_wb_rf_we3  output  1  registered RF write enable.
- o_wb_rf_a3  output  5  registered RF write address.
- o_wb_rf_wd3  output  XLEN  registered RF write data.

Behaviour:
- Reset (i_wb_rst_n=0 at posedge):
  - o_wb_rf_we3=0, o_wb_rf_a3=0, o_wb_rf_wd3=0.
  - o_wb_busy=0.
  - rr pointer=0.
  - o_wb_req_ready is forced to 0 while reset is asserted.
  - Reset mid-transfer drops any registered write; the RF sees no write in the following cycle.
- Arbitration, combinational each cycle:
  - Search i_wb_req_valid starting at index ptr, wrapping NREQ-1 -> 0.
  - The first valid index wins; its o_wb_req_ready bit=1 and all others are 0.
  - No valid request -> ready=0.
  - Ready never asserts without the matching valid.
- Handshake:
  - Transfer happens when valid[k] & ready[k] at a posedge.
  - Requesters hold rd/data stable while valid and not ready. Valid must not drop before acceptance (a bench assertion checks this).
- Pointer:
  - On a transfer by k, ptr <= (k==NREQ-1) ? 0 : k+1.
  - No transfer -> ptr holds.
- Write port latency: 1 cycle.
  - Transfer at posedge N -> from posedge N to posedge N+1: we3=1, a3=rd, wd3=data.
  - The RF captures on the negedge inside that cycle.
  - No transfer at posedge N -> we3=0 for the next cycle; a3 and wd3 hold their last values.
  - One write per cycle max, so back-to-back transfers give back-to-back we3 pulses.
- rd==0:
  - The transfer is accepted and consumes the grant (pointer advances).
  - we3 stays 0; the scoreboard is unchanged.
- Scoreboard, per-bit update at posedge:
  - set: i_wb_iss_valid & (i_wb_iss_rd==r) & r!=0.
  - clr: transfer with rd==r.
  - Next value: flush ? 0 : set ? 1 : clr ? 0 : hold.
  - Simultaneous set and clr on the same r: set wins, since the new producer supersedes.
  - Flush overrides set and clr. Flush does not cancel a transfer already registered on the write port; that write still occurs.
  - busy[0] is constant 0.
  - Writeback to a non-busy register is legal: the write occurs and the busy bit stays 0.
- Issue stall policy (not issuing to a busy rd) is the issue stage's job; this block only reports busy.

Decomposition:
- Shared package riscv_core_pkg: XLEN=64, REG_ADDR_W=5, NUM_REGS=32, zero-register index constant.
- One natural sub-module, riscv_core_rr_arb: parameterized NREQ round-robin arbiter.
  - Inputs: req, ptr.
  - Outputs: one-hot grant and winner index.
  - Purely combinational. The pointer register lives in the parent.
- The scoreboard and output register are in the parent.

Test Plan:
- Reset: hold i_wb_rst_n=0 for 2 cycles with all valids=1 -> ready=0, we3=0, busy=0. First cycle after release grants req0.
- Single write: req1 valid, rd=5, data=64'hDEAD_BEEF_0000_0001, with rd 5 issued 3 cycles earlier -> ready[1]=1 for one cycle; next cycle we3=1, a3=5, wd3=DEAD_BEEF_0000_0001; busy[5] goes 1 -> 0 at that same edge.
- Round-robin: all 3 valid continuously with rd=1,2,3 -> grant order 0,1,2,0,1,2; we3 high every cycle; a3 sequence 1,2,3,1,...
- Same-edge conflict: issue rd=7 while the LSU writeback of rd=7 is accepted -> write occurs and busy[7]=1 afterwards. Flush on the following cycle -> busy=0 and the registered write to rd 7 still appears.
- x0 handling: req2 valid with rd=0 and issue rd=0 -> ready[2]=1, ptr advances to 0, we3 stays 0, busy[0]=0.
- Reset mid-operation: assert reset in the same cycle a transfer would occur -> no we3 pulse next cycle, ptr=0, busy=0.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared core constants: data width and register-file geometry.
package riscv_core_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/riscv_core_rr_arb.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins; the pointer register is owned by the caller.
module riscv_core_rr_arb #(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/riscv_core_wb_arb.sv
// Writeback arbiter: round-robin sharing of the RF write port among NREQ
// requesters, plus a 32-entry busy scoreboard for pending destinations.
module riscv_core_wb_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = riscv_core_pkg::XLEN
) (
    input  logic                                    i_wb_clk,
    input  logic                                    i_wb_rst_n,
    input  logic [NREQ-1:0]                         i_wb_req_valid,
    input  logic [NREQ*riscv_core_pkg::REG_ADDR_W-1:0] i_wb_req_rd,
    input  logic [NREQ*XLEN-1:0]                    i_wb_req_data,
    output logic [NREQ-1:0]                         o_wb_req_ready,
    input  logic                                    i_wb_iss_valid,
    input  logic [riscv_core_pkg::REG_ADDR_W-1:0]   i_wb_iss_rd,
    input  logic                                    i_wb_flush,
    output logic [riscv_core_pkg::NUM_REGS-1:0]     o_wb_busy,
    output logic                                    o_wb_rf_we3,
    output logic [riscv_core_pkg::REG_ADDR_W-1:0]   o_wb_rf_a3,
    output logic [XLEN-1:0]                         o_wb_rf_wd3
);

    import riscv_core_pkg::*;

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]           ptr;
    logic [PW-1:0]           win;
    logic [NREQ-1:0]         grant;
    logic                    xfer;
    logic                    wr_en;
    logic [REG_ADDR_W-1:0]   sel_rd;
    logic [XLEN-1:0]         sel_data;
    logic [NUM_REGS-1:0]     busy_next;

    riscv_core_rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (i_wb_req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win)
    );

    assign o_wb_req_ready = i_wb_rst_n ? grant : '0;
    assign xfer           = |(i_wb_req_valid & o_wb_req_ready);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_rd   = i_wb_req_rd[k*REG_ADDR_W +: REG_ADDR_W];
                sel_data = i_wb_req_data[k*XLEN +: XLEN];
            end
        end
    end

    // x0 transfers still consume the grant but never reach the RF.
    assign wr_en = xfer && (sel_rd != REG_ZERO);

    // Issue beats writeback on the same register: the new producer supersedes.
    always_comb begin
        busy_next = o_wb_busy;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (i_wb_iss_valid && (i_wb_iss_rd == REG_ADDR_W'(r)))
                busy_next[r] = 1'b1;
            else if (wr_en && (sel_rd == REG_ADDR_W'(r)))
                busy_next[r] = 1'b0;
        end
        if (i_wb_flush)
            busy_next = '0;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            o_wb_rf_we3 <= 1'b0;
            o_wb_rf_a3  <= '0;
            o_wb_rf_wd3 <= '0;
            o_wb_busy   <= '0;
            ptr         <= '0;
        end else begin
            o_wb_rf_we3 <= wr_en;
            if (wr_en) begin
                o_wb_rf_a3  <= sel_rd;
                o_wb_rf_wd3 <= sel_data;
            end
            if (xfer)
                ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            o_wb_busy <= busy_next;
        end
    end

endmodule
